// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default widths, reset PC, sequencer states and
// redirect source codes.
package pipe_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } pc_state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_TRAP = 2'd1,
    SRC_BR   = 2'd2,
    SRC_JAL  = 2'd3
  } redir_src_e;

endpackage

// File: rtl/redirect_prio.sv
// Combinational redirect arbiter: trap beats taken branch beats JAL.
module redirect_prio
  import pipe_pkg::*;
#(
  parameter int XLEN = pipe_pkg::XLEN
) (
  input  logic             trap_valid,
  input  logic [XLEN-1:0]  trap_target,
  input  logic             br_valid,
  input  logic             br_taken,
  input  logic [XLEN-1:0]  br_target,
  input  logic             jal_valid,
  input  logic [XLEN-1:0]  jal_target,
  output redir_src_e       src,
  output logic [XLEN-1:0]  target
);

  always_comb begin
    src    = SRC_NONE;
    target = '0;
    if (trap_valid) begin
      src    = SRC_TRAP;
      target = trap_target;
    end else if (br_valid && br_taken) begin
      src    = SRC_BR;
      target = br_target;
    end else if (jal_valid) begin
      src    = SRC_JAL;
      target = jal_target;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Next-PC sequencer: picks sequential PC or a prioritised redirect, and parks a
// redirect in HOLD until IF is ready so producers never have to retry.
module pc_redirect_ctrl
  import pipe_pkg::*;
#(
  parameter int              XLEN     = pipe_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(pipe_pkg::RESET_PC),
  parameter int              CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   if_id_pc_out,
  input  logic              if_ready,
  input  logic              ex_br_valid,
  input  logic              ex_br_taken,
  input  logic [XLEN-1:0]   ex_br_target,
  input  logic              id_jal_valid,
  input  logic [XLEN-1:0]   id_jal_target,
  input  logic              trap_valid,
  input  logic [XLEN-1:0]   trap_target,
  output logic [XLEN-1:0]   id_if_pc_in,
  output logic              pc_load,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              redirect_pending,
  output logic [CNT_W-1:0]  redirect_cnt
);

  pc_state_e         state_q, state_d;
  logic [XLEN-1:0]   held_pc_q, held_pc_d;
  logic [CNT_W-1:0]  redirect_cnt_q, redirect_cnt_d;

  redir_src_e        ev_src;
  logic [XLEN-1:0]   ev_target;
  logic [XLEN-1:0]   seq_pc;

  redirect_prio #(.XLEN(XLEN)) u_prio (
    .trap_valid  (trap_valid),
    .trap_target (trap_target),
    .br_valid    (ex_br_valid),
    .br_taken    (ex_br_taken),
    .br_target   (ex_br_target),
    .jal_valid   (id_jal_valid),
    .jal_target  (id_jal_target),
    .src         (ev_src),
    .target      (ev_target)
  );

  assign seq_pc       = if_id_pc_out + XLEN'(4);
  assign redirect_cnt = redirect_cnt_q;

  always_comb begin
    state_d          = state_q;
    held_pc_d        = held_pc_q;
    redirect_cnt_d   = redirect_cnt_q;
    id_if_pc_in      = held_pc_q;
    pc_load          = 1'b0;
    flush_if_id      = 1'b0;
    flush_id_ex      = 1'b0;
    redirect_pending = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        pc_load = if_ready;
        if (ev_src != SRC_NONE) begin
          // An early redirect simply replaces the boot address.
          id_if_pc_in    = ev_target;
          held_pc_d      = ev_target;
          redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
          flush_if_id    = 1'b1;
          flush_id_ex    = (ev_src != SRC_JAL);
        end
        if (if_ready) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (ev_src != SRC_NONE) begin
          id_if_pc_in    = ev_target;
          redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
          flush_if_id    = 1'b1;
          flush_id_ex    = (ev_src != SRC_JAL);
          pc_load        = if_ready;
          if (!if_ready) begin
            held_pc_d = ev_target;
            state_d   = ST_HOLD;
          end
        end else begin
          id_if_pc_in = seq_pc;
          pc_load     = if_ready;
        end
      end
      ST_HOLD: begin
        // Branch/JAL requests here come from squashed instructions.
        redirect_pending = 1'b1;
        flush_if_id      = 1'b1;
        pc_load          = if_ready;
        if (trap_valid) begin
          flush_id_ex    = 1'b1;
          redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
          if (if_ready) begin
            id_if_pc_in = trap_target;
            state_d     = ST_RUN;
          end else begin
            held_pc_d = trap_target;
          end
        end else if (if_ready) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase

    // Keep IF quiet while reset is held, whatever the request inputs do.
    if (!rst) begin
      id_if_pc_in      = RESET_PC;
      pc_load          = 1'b0;
      flush_if_id      = 1'b0;
      flush_id_ex      = 1'b0;
      redirect_pending = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_BOOT;
      held_pc_q      <= RESET_PC;
      redirect_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      held_pc_q      <= held_pc_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: each driven cycle pushes its expected
// outputs, a monitor pops and compares them late in the same cycle.
module tb_pc_redirect_ctrl;

  localparam int XLEN  = 32;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic             chk_pc;
    logic [XLEN-1:0]  pc;
    logic             load;
    logic             fif;
    logic             fex;
    logic             pend;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [XLEN-1:0]  if_id_pc_out;
  logic             if_ready;
  logic             ex_br_valid;
  logic             ex_br_taken;
  logic [XLEN-1:0]  ex_br_target;
  logic             id_jal_valid;
  logic [XLEN-1:0]  id_jal_target;
  logic             trap_valid;
  logic [XLEN-1:0]  trap_target;
  logic [XLEN-1:0]  id_if_pc_in;
  logic             pc_load;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             redirect_pending;
  logic [CNT_W-1:0] redirect_cnt;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  pc_redirect_ctrl #(.XLEN(XLEN), .RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .if_id_pc_out     (if_id_pc_out),
    .if_ready         (if_ready),
    .ex_br_valid      (ex_br_valid),
    .ex_br_taken      (ex_br_taken),
    .ex_br_target     (ex_br_target),
    .id_jal_valid     (id_jal_valid),
    .id_jal_target    (id_jal_target),
    .trap_valid       (trap_valid),
    .trap_target      (trap_target),
    .id_if_pc_in      (id_if_pc_in),
    .pc_load          (pc_load),
    .flush_if_id      (flush_if_id),
    .flush_id_ex      (flush_id_ex),
    .redirect_pending (redirect_pending),
    .redirect_cnt     (redirect_cnt)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // monitor: sample 4 time units after the driving negedge, before posedge
  always @(negedge clk) begin
    exp_t e;
    #4;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.chk_pc) check_val("pc", 64'(id_if_pc_in), 64'(e.pc));
      check_val("load", 64'(pc_load), 64'(e.load));
      check_val("flush_if_id", 64'(flush_if_id), 64'(e.fif));
      check_val("flush_id_ex", 64'(flush_id_ex), 64'(e.fex));
      check_val("pending", 64'(redirect_pending), 64'(e.pend));
      check_val("cnt", 64'(redirect_cnt), 64'(e.cnt));
    end
  end

  // driver tasks
  task automatic set_idle();
    if_ready      = 1'b1;
    if_id_pc_out  = '0;
    ex_br_valid   = 1'b0;
    ex_br_taken   = 1'b0;
    ex_br_target  = '0;
    id_jal_valid  = 1'b0;
    id_jal_target = '0;
    trap_valid    = 1'b0;
    trap_target   = '0;
  endtask

  task automatic step(input logic chk_pc, input logic [XLEN-1:0] pc, input logic load,
                      input logic fif, input logic fex, input logic pend,
                      input logic [CNT_W-1:0] cnt);
    exp_t e;
    e.chk_pc = chk_pc;
    e.pc     = pc;
    e.load   = load;
    e.fif    = fif;
    e.fex    = fex;
    e.pend   = pend;
    e.cnt    = cnt;
    exp_q.push_back(e);
    @(negedge clk);
    set_idle();
  endtask

  initial begin
    logic [XLEN-1:0]  tgt;
    logic [CNT_W-1:0] cnt;
    rst = 1'b0;
    set_idle();
    repeat (2) @(negedge clk);

    // reset holds outputs quiet even with a trap and if_ready present
    trap_valid = 1'b1; trap_target = 32'h80;
    step(1, 32'h0, 0, 0, 0, 0, 16'd0);

    // boot fetch then sequential
    rst = 1'b1;
    step(1, 32'h0, 1, 0, 0, 0, 16'd0);
    if_id_pc_out = 32'h0;
    step(1, 32'h4, 1, 0, 0, 0, 16'd0);

    // taken branch, zero-cycle redirect
    ex_br_valid = 1; ex_br_taken = 1; ex_br_target = 32'h100;
    step(1, 32'h100, 1, 1, 1, 0, 16'd0);
    if_id_pc_out = 32'h100;
    step(1, 32'h104, 1, 0, 0, 0, 16'd1);

    // not-taken branch is no event
    ex_br_valid = 1; ex_br_taken = 0; ex_br_target = 32'h900; if_id_pc_out = 32'h104;
    step(1, 32'h108, 1, 0, 0, 0, 16'd1);

    // JAL while IF busy: captured, held, then loaded
    id_jal_valid = 1; id_jal_target = 32'h200; if_ready = 0;
    step(0, 32'h0, 0, 1, 0, 0, 16'd1);
    if_ready = 0; ex_br_valid = 1; ex_br_taken = 1; ex_br_target = 32'h300;
    step(1, 32'h200, 0, 1, 0, 1, 16'd2);
    if_ready = 0; id_jal_valid = 1; id_jal_target = 32'h400;
    step(1, 32'h200, 0, 1, 0, 1, 16'd2);
    if_ready = 1;
    step(1, 32'h200, 1, 1, 0, 1, 16'd2);
    if_id_pc_out = 32'h200;
    step(1, 32'h204, 1, 0, 0, 0, 16'd2);

    // trap overrides a held JAL; branch during HOLD is ignored
    id_jal_valid = 1; id_jal_target = 32'h200; if_ready = 0;
    step(0, 32'h0, 0, 1, 0, 0, 16'd2);
    if_ready = 0; trap_valid = 1; trap_target = 32'h80;
    ex_br_valid = 1; ex_br_taken = 1; ex_br_target = 32'h300;
    step(1, 32'h200, 0, 1, 1, 1, 16'd3);
    if_ready = 1; ex_br_valid = 1; ex_br_taken = 1; ex_br_target = 32'h300;
    step(1, 32'h80, 1, 1, 0, 1, 16'd4);
    if_id_pc_out = 32'h80;
    step(1, 32'h84, 1, 0, 0, 0, 16'd4);

    // trap + taken branch + JAL together: trap only, one count
    trap_valid = 1; trap_target = 32'h80;
    ex_br_valid = 1; ex_br_taken = 1; ex_br_target = 32'h100;
    id_jal_valid = 1; id_jal_target = 32'h200;
    step(1, 32'h80, 1, 1, 1, 0, 16'd4);
    if_id_pc_out = 32'h80;
    step(1, 32'h84, 1, 0, 0, 0, 16'd5);

    // PC+4 wraps at the top of the address space
    if_id_pc_out = 32'hFFFF_FFFC;
    step(1, 32'h0, 1, 0, 0, 0, 16'd5);
    // IF busy, no event: nothing loads
    if_ready = 0; if_id_pc_out = 32'h10;
    step(1, 32'h14, 0, 0, 0, 0, 16'd5);

    // drive the counter up to its wrap point with random branch targets
    cnt = 16'd5;
    while (cnt != 16'hFFFF) begin
      tgt = {$urandom_range(32'h3FFF_FFFF, 0), 2'b00};
      ex_br_valid = 1; ex_br_taken = 1; ex_br_target = tgt;
      if_id_pc_out = 32'(cnt);
      step(1, tgt, 1, 1, 1, 0, cnt);
      cnt = cnt + 16'd1;
    end
    id_jal_valid = 1; id_jal_target = 32'h500;
    step(1, 32'h500, 1, 1, 0, 0, 16'hFFFF);
    if_id_pc_out = 32'h500;
    step(1, 32'h504, 1, 0, 0, 0, 16'h0000);

    // reset in the middle of HOLD drops the captured target
    id_jal_valid = 1; id_jal_target = 32'h200; if_ready = 0;
    step(0, 32'h0, 0, 1, 0, 0, 16'd0);
    if_ready = 0;
    step(1, 32'h200, 0, 1, 0, 1, 16'd1);
    rst = 1'b0; if_ready = 1;
    step(1, 32'h0, 0, 0, 0, 0, 16'd0);

    // trap in BOOT while IF busy replaces the boot address
    rst = 1'b1; if_ready = 0; trap_valid = 1; trap_target = 32'h40;
    step(1, 32'h40, 0, 1, 1, 0, 16'd0);
    if_ready = 1;
    step(1, 32'h40, 1, 0, 0, 0, 16'd1);
    if_id_pc_out = 32'h40;
    step(1, 32'h44, 1, 0, 0, 0, 16'd1);

    @(negedge clk);
    check_val("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
